// File: rtl/tc_pkg.sv
// Shared types and defaults for the two's-complement word controller.
package tc_pkg;

  localparam int TC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tc_state_e;

endpackage

// File: rtl/tc_serial_cell.sv
// Bit-serial two's-complement cell: passes bits until the first 1, inverts after it.
// Combinational out_bit, one register of state; clr wins over en.
module tc_serial_cell (
  input  logic t_clock,
  input  logic r_n,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  output logic out_bit
);

  logic seen_one_q;
  logic seen_one_d;

  always_comb begin
    seen_one_d = seen_one_q;
    if (clr) begin
      seen_one_d = 1'b0;
    end else if (en && in_bit) begin
      seen_one_d = 1'b1;
    end
  end

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  assign out_bit = seen_one_q ? ~in_bit : in_bit;

endmodule

// File: rtl/tc_word_ctrl.sv
// Word-serial negator: accepts a word in IDLE, result valid WIDTH cycles later, held until out_ready or flush.
// Optional most-negative-operand flag on ovf when TC_OVF_EN is defined.
module tc_word_ctrl
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_DEFAULT_WIDTH
) (
  input  logic             t_clock,
  input  logic             r_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
`ifdef TC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  tc_state_e        state_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             accept;
  logic             cell_en;
  logic             cell_out;

`ifdef TC_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
  logic min_q;
  logic ovf_q;
`endif

  assign accept  = in_valid && in_ready_q;
  assign cell_en = (state_q == SHIFT) && !flush;
  assign cnt_d   = cnt_q + 1'b1;
  // Cell output enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign res_d   = {cell_out, res_q[WIDTH-1:1]};

  tc_serial_cell u_cell (
    .t_clock (t_clock),
    .r_n     (r_n),
    .clr     (accept),
    .en      (cell_en),
    .in_bit  (opnd_q[0]),
    .out_bit (cell_out)
  );

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TC_OVF_EN
      min_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= SHIFT;
            opnd_q     <= in_data;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef TC_OVF_EN
            min_q      <= (in_data == MOST_NEG);
`endif
          end
        end
        SHIFT: begin
          if (flush) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            opnd_q <= opnd_q >> 1;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            if (cnt_q == LAST) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
`ifdef TC_OVF_EN
              ovf_q       <= min_q;
`endif
            end
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TC_OVF_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
  assign busy      = busy_q;
`ifdef TC_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
